upd_loader: RTL and testbench
=============================

# upd_loader

Load sequencer for the upd77c25 DSP core: accepts an MCU byte stream, packs it into 24-bit program words and 16-bit data-ROM words, and drives the core's PGM_WR/DAT_WR upload ports. It also owns the core's RST line, holding the DSP in reset while loading and releasing it cleanly afterwards. It sits between the MCU command/data path and the upd77c25 instance in the top level.

## Interface
- PGM_AW, 11, program ROM address width (2048 words)
- DAT_AW, 10, data ROM address width (1024 words)
- RST_HOLD, 16, CLK cycles DSP_RST stays high after FINISH before release (≥1)
- CLK  in  1  system clock; all logic on rising edge
- nRST  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  one-cycle command strobe
- CMD  in  2  0=LOAD_PGM, 1=LOAD_DAT, 2=FINISH, 3=HALT
- BYTE_VALID  in  1  byte offered
- BYTE  in  8  byte data
- BYTE_READY  out  1  byte accepted when BYTE_VALID && BYTE_READY
- PGM_WR  out  1  one-cycle program write strobe to core
- PGM_DI  out  24  program word
- PGM_WR_ADDR  out  PGM_AW  program word address
- DAT_WR  out  1  one-cycle data write strobe to core
- DAT_DI  out  16  data word
- DAT_WR_ADDR  out  DAT_AW  data word address
- DSP_RST  out  1  active-high reset to the core's RST
- BUSY  out  1  high in any state except IDLE and RUN
- LOADED  out  1  sticky: release completed
- PART_ERR  out  1  sticky: FINISH/new LOAD arrived with a partial word pending
- WRAPPED  out  1  sticky: an address counter wrapped past its max

## Operation
- States: IDLE, COLLECT, WRITE, HOLD, RUN.
- Reset: state IDLE, DSP_RST=1, BYTE_READY=0, strobes 0, DI/address outputs 0, LOADED/PART_ERR/WRAPPED 0, byte index 0, mode PGM.
- IDLE: BYTE_READY=0; DSP_RST=1. LOAD_PGM/LOAD_DAT -> COLLECT with mode set, that mode's address counter=0, byte index=0, LOADED, PART_ERR and WRAPPED cleared.
- COLLECT: BYTE_READY=1. Bytes packed LSB first: PGM needs 3 bytes (byte0->[7:0], byte1->[15:8], byte2->[23:16]); DAT needs 2. On the accepted final byte -> WRITE.
- WRITE: BYTE_READY=0; assert PGM_WR or DAT_WR for exactly one cycle with the current DI/address, then increment the address (modulo 2^AW; wrap sets WRAPPED), byte index=0 -> COLLECT.
- FINISH in COLLECT: partial word (index≠0) discarded, PART_ERR set; -> HOLD with counter=RST_HOLD. FINISH in WRITE is deferred one cycle: the write completes, then -> HOLD.
- LOAD_PGM/LOAD_DAT in COLLECT: partial word discarded (PART_ERR if index≠0); restart with new mode, address 0. Other-mode address counter is untouched, so program and data may be loaded in either order.
- HOLD: DSP_RST=1, counter decrements; at 0 -> RUN, DSP_RST=0, LOADED=1.
- RUN: DSP_RST=0, BYTE_READY=0. LOAD_* -> COLLECT, DSP_RST=1 the same edge.
- HALT from any state: -> IDLE, DSP_RST=1, partial word dropped (no PART_ERR), LOADED cleared.
- FINISH in IDLE/HOLD/RUN is ignored. Bytes offered outside COLLECT are not accepted.

## Timing
- Byte-to-strobe latency: strobe is asserted the cycle after the final byte is accepted; peak throughput 3 bytes/4 cycles (PGM), 2 bytes/3 cycles (DAT).
- PGM_DI/DAT_DI and addresses are registered and stable while the strobe is high.
- DSP_RST falls exactly RST_HOLD+1 cycles after the FINISH strobe is sampled in COLLECT.
- nRST assertion mid-load: all outputs take reset values immediately (asynchronous); the core is back in reset.
- CMD and BYTE in the same cycle: command has priority; the byte is not accepted (BYTE_READY is combinationally forced low when CMD_VALID is high).

## Structure
- Package upd_loader_pkg: state enum, CMD encodings (CMD_LOAD_PGM, CMD_LOAD_DAT, CMD_FINISH, CMD_HALT), bytes-per-word constants.
- One sub-module: upd_word_packer (byte shift/pack register with index counter, width 24, mode selects 2- or 3-byte completion).

## Test plan
- LOAD_PGM, bytes 01 02 03 04 05 06 -> PGM_WR twice: 030201 @0, 060504 @1; FINISH -> DSP_RST low after 17 cycles, LOADED=1.
- LOAD_DAT, bytes 34 12 -> DAT_WR 1234 @0; then LOAD_PGM, 3 bytes -> program write @0 and data address untouched.
- LOAD_PGM, 2048×3 bytes plus 3 more -> final write at address 0, WRAPPED=1.
- LOAD_DAT, one byte 7F, FINISH -> no DAT_WR, PART_ERR=1, release still occurs.
- CMD_VALID together with BYTE_VALID in COLLECT -> byte not accepted; HALT during HOLD -> IDLE, DSP_RST stays 1, LOADED=0.
- nRST pulsed low mid-word -> all outputs at reset values; subsequent LOAD_PGM starts at address 0 with a clean packer.

Source files
------------

// File: rtl/upd_loader_pkg.sv
// ============================================================================
// Module      : upd_loader_pkg
// Description : Shared types and constants for the upd77c25 load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package upd_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RUN     = 3'd4
    } state_e;

    typedef enum logic {
        MODE_PGM = 1'b0,
        MODE_DAT = 1'b1
    } mode_e;

    localparam logic [1:0] CMD_LOAD_PGM = 2'd0;
    localparam logic [1:0] CMD_LOAD_DAT = 2'd1;
    localparam logic [1:0] CMD_FINISH   = 2'd2;
    localparam logic [1:0] CMD_HALT     = 2'd3;

    localparam logic [1:0] PGM_BYTES = 2'd3;
    localparam logic [1:0] DAT_BYTES = 2'd2;

    // Byte index of the final byte of a word in the given mode.
    function automatic logic [1:0] last_idx(input mode_e m);
        return (m == MODE_PGM) ? (PGM_BYTES - 2'd1) : (DAT_BYTES - 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/upd_word_packer.sv
// ============================================================================
// Module      : upd_word_packer
// Description : Packs bytes LSB-first into a 24-bit word; completes after
//               3 bytes (program) or 2 bytes (data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upd_word_packer
    import upd_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  mode_e       i_mode,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [23:0] o_word,
    output logic [1:0]  o_idx,
    output logic        o_last
);

    logic [23:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] w_merged;

    // Word as it looks with the offered byte dropped into its lane.
    always_comb begin
        w_merged = word_q;
        case (idx_q)
            2'd0:    w_merged[7:0]   = i_byte;
            2'd1:    w_merged[15:8]  = i_byte;
            default: w_merged[23:16] = i_byte;
        endcase
    end

    assign o_last = i_accept && (idx_q == last_idx(i_mode));
    assign o_word = w_merged;
    assign o_idx  = idx_q;

    // Clear wins over accept; a completed word restarts the packer empty.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (i_clr) begin
            word_d = '0;
            idx_d  = '0;
        end else if (o_last) begin
            word_d = '0;
            idx_d  = '0;
        end else if (i_accept) begin
            word_d = w_merged;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Packer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/upd_loader.sv
// ============================================================================
// Module      : upd_loader
// Description : Load sequencer for the upd77c25 core: packs MCU bytes into
//               program/data ROM words, drives the upload strobes and owns
//               the core reset line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upd_loader
    import upd_loader_pkg::*;
#(
    parameter int PGM_AW   = 11,
    parameter int DAT_AW   = 10,
    parameter int RST_HOLD = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              CMD_VALID,
    input  logic [1:0]        CMD,
    input  logic              BYTE_VALID,
    input  logic [7:0]        BYTE,
    output logic              BYTE_READY,
    output logic              PGM_WR,
    output logic [23:0]       PGM_DI,
    output logic [PGM_AW-1:0] PGM_WR_ADDR,
    output logic              DAT_WR,
    output logic [15:0]       DAT_DI,
    output logic [DAT_AW-1:0] DAT_WR_ADDR,
    output logic              DSP_RST,
    output logic              BUSY,
    output logic              LOADED,
    output logic              PART_ERR,
    output logic              WRAPPED
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [PGM_AW-1:0]   pgm_addr_q, pgm_addr_d;
    logic [DAT_AW-1:0]   dat_addr_q, dat_addr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                loaded_q, loaded_d;
    logic                part_err_q, part_err_d;
    logic                wrapped_q, wrapped_d;
    logic                pgm_wr_q, pgm_wr_d;
    logic                dat_wr_q, dat_wr_d;
    logic [23:0]         pgm_di_q, pgm_di_d;
    logic [15:0]         dat_di_q, dat_di_d;
    logic [PGM_AW-1:0]   pgm_wr_addr_q, pgm_wr_addr_d;
    logic [DAT_AW-1:0]   dat_wr_addr_q, dat_wr_addr_d;

    logic                w_load, w_halt, w_accept;
    logic                w_restart, w_fresh, w_pack_clr;
    logic [23:0]         w_pack_word;
    logic [1:0]          w_pack_idx;
    logic                w_pack_last;

    assign w_load     = CMD_VALID && ((CMD == CMD_LOAD_PGM) || (CMD == CMD_LOAD_DAT));
    assign w_halt     = CMD_VALID && (CMD == CMD_HALT);
    // A command in the same cycle always blocks the byte.
    assign BYTE_READY = (state_q == ST_COLLECT) && !CMD_VALID;
    assign w_accept   = BYTE_VALID && BYTE_READY;

    upd_word_packer u_packer (
        .clk      (CLK),
        .rst_n    (nRST),
        .i_clr    (w_pack_clr),
        .i_mode   (mode_q),
        .i_accept (w_accept),
        .i_byte   (BYTE),
        .o_word   (w_pack_word),
        .o_idx    (w_pack_idx),
        .o_last   (w_pack_last)
    );

    // Next-state, address counters, sticky flags and upload strobes.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        pgm_addr_d    = pgm_addr_q;
        dat_addr_d    = dat_addr_q;
        hold_cnt_d    = hold_cnt_q;
        loaded_d      = loaded_q;
        part_err_d    = part_err_q;
        wrapped_d     = wrapped_q;
        pgm_wr_d      = 1'b0;
        dat_wr_d      = 1'b0;
        pgm_di_d      = pgm_di_q;
        dat_di_d      = dat_di_q;
        pgm_wr_addr_d = pgm_wr_addr_q;
        dat_wr_addr_d = dat_wr_addr_q;
        w_restart     = 1'b0;
        w_fresh       = 1'b0;
        w_pack_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_load) begin
                    w_restart = 1'b1;
                    w_fresh   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (CMD_VALID) begin
                    if (w_load) begin
                        w_restart = 1'b1;
                        if (w_pack_idx != 2'd0) part_err_d = 1'b1;
                    end else if (CMD == CMD_FINISH) begin
                        if (w_pack_idx != 2'd0) part_err_d = 1'b1;
                        w_pack_clr = 1'b1;
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_W'(RST_HOLD);
                    end
                end else if (w_pack_last) begin
                    state_d = ST_WRITE;
                    if (mode_q == MODE_PGM) begin
                        pgm_wr_d      = 1'b1;
                        pgm_di_d      = w_pack_word;
                        pgm_wr_addr_d = pgm_addr_q;
                    end else begin
                        dat_wr_d      = 1'b1;
                        dat_di_d      = w_pack_word[15:0];
                        dat_wr_addr_d = dat_addr_q;
                    end
                end
            end
            ST_WRITE: begin
                // Strobe is on the port this cycle; advance to the next word.
                if (mode_q == MODE_PGM) begin
                    pgm_addr_d = pgm_addr_q + PGM_AW'(1);
                    if (&pgm_addr_q) wrapped_d = 1'b1;
                end else begin
                    dat_addr_d = dat_addr_q + DAT_AW'(1);
                    if (&dat_addr_q) wrapped_d = 1'b1;
                end
                state_d = ST_COLLECT;
                if (w_load) begin
                    w_restart = 1'b1;
                end else if (CMD_VALID && (CMD == CMD_FINISH)) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_W'(RST_HOLD);
                end
            end
            ST_HOLD: begin
                // Release sequence runs to completion; only HALT aborts it.
                if (hold_cnt_q == '0) begin
                    state_d  = ST_RUN;
                    loaded_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (w_load) begin
                    w_restart = 1'b1;
                    w_fresh   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_restart) begin
            state_d    = ST_COLLECT;
            w_pack_clr = 1'b1;
            if (CMD == CMD_LOAD_PGM) begin
                mode_d     = MODE_PGM;
                pgm_addr_d = '0;
            end else begin
                mode_d     = MODE_DAT;
                dat_addr_d = '0;
            end
        end
        if (w_fresh) begin
            loaded_d   = 1'b0;
            part_err_d = 1'b0;
            wrapped_d  = 1'b0;
        end
        if (w_halt) begin
            state_d    = ST_IDLE;
            w_pack_clr = 1'b1;
            loaded_d   = 1'b0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_PGM;
            pgm_addr_q    <= '0;
            dat_addr_q    <= '0;
            hold_cnt_q    <= '0;
            loaded_q      <= 1'b0;
            part_err_q    <= 1'b0;
            wrapped_q     <= 1'b0;
            pgm_wr_q      <= 1'b0;
            dat_wr_q      <= 1'b0;
            pgm_di_q      <= '0;
            dat_di_q      <= '0;
            pgm_wr_addr_q <= '0;
            dat_wr_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            pgm_addr_q    <= pgm_addr_d;
            dat_addr_q    <= dat_addr_d;
            hold_cnt_q    <= hold_cnt_d;
            loaded_q      <= loaded_d;
            part_err_q    <= part_err_d;
            wrapped_q     <= wrapped_d;
            pgm_wr_q      <= pgm_wr_d;
            dat_wr_q      <= dat_wr_d;
            pgm_di_q      <= pgm_di_d;
            dat_di_q      <= dat_di_d;
            pgm_wr_addr_q <= pgm_wr_addr_d;
            dat_wr_addr_q <= dat_wr_addr_d;
        end
    end

    // The core is held in reset in every state except RUN.
    assign DSP_RST     = (state_q != ST_RUN);
    assign BUSY        = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign PGM_WR      = pgm_wr_q;
    assign PGM_DI      = pgm_di_q;
    assign PGM_WR_ADDR = pgm_wr_addr_q;
    assign DAT_WR      = dat_wr_q;
    assign DAT_DI      = dat_di_q;
    assign DAT_WR_ADDR = dat_wr_addr_q;
    assign LOADED      = loaded_q;
    assign PART_ERR    = part_err_q;
    assign WRAPPED     = wrapped_q;

endmodule

`default_nettype wire

// File: tb/tb_upd_loader.sv
// ============================================================================
// Module      : tb_upd_loader
// Description : Directed self-checking bench for upd_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_upd_loader;

    localparam logic [1:0] C_LOAD_PGM = 2'd0;
    localparam logic [1:0] C_LOAD_DAT = 2'd1;
    localparam logic [1:0] C_FINISH   = 2'd2;
    localparam logic [1:0] C_HALT     = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        CMD_VALID;
    logic [1:0]  CMD;
    logic        BYTE_VALID;
    logic [7:0]  BYTE;
    logic        BYTE_READY;
    logic        PGM_WR;
    logic [23:0] PGM_DI;
    logic [10:0] PGM_WR_ADDR;
    logic        DAT_WR;
    logic [15:0] DAT_DI;
    logic [9:0]  DAT_WR_ADDR;
    logic        DSP_RST;
    logic        BUSY;
    logic        LOADED;
    logic        PART_ERR;
    logic        WRAPPED;

    int n_tests = 0;
    int n_fail  = 0;

    logic [34:0] pgm_q[$];
    logic [25:0] dat_q[$];

    upd_loader #(
        .PGM_AW   (11),
        .DAT_AW   (10),
        .RST_HOLD (16)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .CMD_VALID   (CMD_VALID),
        .CMD         (CMD),
        .BYTE_VALID  (BYTE_VALID),
        .BYTE        (BYTE),
        .BYTE_READY  (BYTE_READY),
        .PGM_WR      (PGM_WR),
        .PGM_DI      (PGM_DI),
        .PGM_WR_ADDR (PGM_WR_ADDR),
        .DAT_WR      (DAT_WR),
        .DAT_DI      (DAT_DI),
        .DAT_WR_ADDR (DAT_WR_ADDR),
        .DSP_RST     (DSP_RST),
        .BUSY        (BUSY),
        .LOADED      (LOADED),
        .PART_ERR    (PART_ERR),
        .WRAPPED     (WRAPPED)
    );

    always #5 CLK = ~CLK;

    // Log every upload strobe as {address, word}.
    always @(negedge CLK) begin
        if (PGM_WR === 1'b1) pgm_q.push_back({PGM_WR_ADDR, PGM_DI});
        if (DAT_WR === 1'b1) dat_q.push_back({DAT_WR_ADDR, DAT_DI});
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] c);
        CMD_VALID = 1'b1;
        CMD       = c;
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        BYTE_VALID = 1'b1;
        BYTE       = b;
        #1;
        while (BYTE_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 20) check("byte_ready_timeout", 64'(n), 64'd0);
        @(negedge CLK);
        BYTE_VALID = 1'b0;
    endtask

    task automatic wait_release(output int k);
        k = 0;
        while (DSP_RST === 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        nRST       = 1'b0;
        CMD_VALID  = 1'b0;
        CMD        = 2'd0;
        BYTE_VALID = 1'b0;
        BYTE       = 8'h00;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_dsp_rst",  64'(DSP_RST),     64'd1);
        check("rst_ready",    64'(BYTE_READY),  64'd0);
        check("rst_pgm_wr",   64'(PGM_WR),      64'd0);
        check("rst_dat_wr",   64'(DAT_WR),      64'd0);
        check("rst_pgm_di",   64'(PGM_DI),      64'd0);
        check("rst_pgm_addr", 64'(PGM_WR_ADDR), 64'd0);
        check("rst_dat_di",   64'(DAT_DI),      64'd0);
        check("rst_dat_addr", 64'(DAT_WR_ADDR), 64'd0);
        check("rst_busy",     64'(BUSY),        64'd0);
        check("rst_flags",    64'({LOADED, PART_ERR, WRAPPED}), 64'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // Program load of two words and release
        send_cmd(C_LOAD_PGM);
        #1;
        check("t1_busy",  64'(BUSY),       64'd1);
        check("t1_ready", 64'(BYTE_READY), 64'd1);
        #1;
        pgm_q.delete();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("t1_wr0_strobe", 64'(PGM_WR),      64'd1);
        check("t1_wr0_di",     64'(PGM_DI),      64'h030201);
        check("t1_wr0_addr",   64'(PGM_WR_ADDR), 64'd0);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        check("t1_wr1_di",   64'(PGM_DI),      64'h060504);
        check("t1_wr1_addr", 64'(PGM_WR_ADDR), 64'd1);
        @(negedge CLK);
        #2;
        check("t1_wr_count", 64'(pgm_q.size()), 64'd2);
        check("t1_log0", 64'(pgm_q[0]), 64'({11'd0, 24'h030201}));
        check("t1_log1", 64'(pgm_q[1]), 64'({11'd1, 24'h060504}));
        send_cmd(C_FINISH);
        check("t1_hold_rst", 64'(DSP_RST), 64'd1);
        wait_release(k);
        check("t1_release_cycles", 64'(k), 64'd17);
        check("t1_loaded", 64'(LOADED), 64'd1);
        check("t1_busy_run", 64'(BUSY), 64'd0);

        // Data word, then program word; data outputs untouched
        send_cmd(C_LOAD_DAT);
        check("t2_dsp_rst", 64'(DSP_RST), 64'd1);
        send_byte(8'h34);
        send_byte(8'h12);
        check("t2_dat_strobe", 64'(DAT_WR),      64'd1);
        check("t2_dat_di",     64'(DAT_DI),      64'h1234);
        check("t2_dat_addr",   64'(DAT_WR_ADDR), 64'd0);
        @(negedge CLK);
        send_cmd(C_LOAD_PGM);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("t2_pgm_di",       64'(PGM_DI),      64'hCCBBAA);
        check("t2_pgm_addr",     64'(PGM_WR_ADDR), 64'd0);
        check("t2_dat_di_keep",  64'(DAT_DI),      64'h1234);
        check("t2_dat_wr_quiet", 64'(DAT_WR),      64'd0);
        @(negedge CLK);

        // Program address wrap
        send_cmd(C_HALT);
        send_cmd(C_LOAD_PGM);
        check("t3_wrapped_clr", 64'(WRAPPED), 64'd0);
        #2;
        pgm_q.delete();
        for (int i = 0; i < 2048; i++) begin
            send_byte(i[7:0]);
            send_byte({5'd0, i[10:8]});
            send_byte(8'hA5);
        end
        @(negedge CLK);
        #2;
        check("t3_count",   64'(pgm_q.size()), 64'd2048);
        check("t3_log5",    64'(pgm_q[5]),     64'({11'd5, 24'hA50005}));
        check("t3_log2047", 64'(pgm_q[2047]),  64'({11'd2047, 24'hA507FF}));
        check("t3_wrapped", 64'(WRAPPED), 64'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t3_wrap_addr", 64'(PGM_WR_ADDR), 64'd0);
        check("t3_wrap_di",   64'(PGM_DI),      64'h332211);
        @(negedge CLK);

        // Partial data word then FINISH
        send_cmd(C_HALT);
        send_cmd(C_LOAD_DAT);
        check("t4_part_clr", 64'(PART_ERR), 64'd0);
        #2;
        dat_q.delete();
        send_byte(8'h7F);
        send_cmd(C_FINISH);
        check("t4_part_err", 64'(PART_ERR), 64'd1);
        wait_release(k);
        check("t4_release_cycles", 64'(k), 64'd17);
        check("t4_loaded", 64'(LOADED), 64'd1);
        #2;
        check("t4_no_dat_wr", 64'(dat_q.size()), 64'd0);

        // Command and byte together; HALT during HOLD
        @(negedge CLK);
        send_cmd(C_LOAD_PGM);
        CMD_VALID  = 1'b1;
        CMD        = C_LOAD_PGM;
        BYTE_VALID = 1'b1;
        BYTE       = 8'h55;
        #1;
        check("t5_ready_blocked", 64'(BYTE_READY), 64'd0);
        @(negedge CLK);
        CMD_VALID  = 1'b0;
        BYTE_VALID = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("t5_di",   64'(PGM_DI),      64'h030201);
        check("t5_addr", 64'(PGM_WR_ADDR), 64'd0);
        @(negedge CLK);
        send_cmd(C_FINISH);
        repeat (3) @(negedge CLK);
        check("t5_hold_busy", 64'(BUSY), 64'd1);
        send_cmd(C_HALT);
        check("t5_halt_busy",   64'(BUSY),    64'd0);
        check("t5_halt_rst",    64'(DSP_RST), 64'd1);
        check("t5_halt_loaded", 64'(LOADED),  64'd0);
        repeat (25) @(negedge CLK);
        check("t5_halt_rst_stays", 64'(DSP_RST), 64'd1);

        // Asynchronous reset in the middle of a word
        send_cmd(C_LOAD_PGM);
        send_byte(8'h0D);
        send_byte(8'h0E);
        send_byte(8'h0F);
        @(negedge CLK);
        send_byte(8'h9A);
        send_byte(8'hBC);
        #1;
        nRST = 1'b0;
        #1;
        check("t6_rst_dsp",   64'(DSP_RST),     64'd1);
        check("t6_rst_ready", 64'(BYTE_READY),  64'd0);
        check("t6_rst_busy",  64'(BUSY),        64'd0);
        check("t6_rst_di",    64'(PGM_DI),      64'd0);
        check("t6_rst_addr",  64'(PGM_WR_ADDR), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        send_cmd(C_LOAD_PGM);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t6_after_strobe", 64'(PGM_WR),      64'd1);
        check("t6_after_di",     64'(PGM_DI),      64'h332211);
        check("t6_after_addr",   64'(PGM_WR_ADDR), 64'd0);

        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
